l1d_fifo_enq_sched: RTL and testbench

- Enqueue-side scheduler for the L1D single-port data/valid-output FIFO.
- Shares the FIFO's single enqueue port among REQ_NUM requesters with a round-robin arbiter.
- Above a high-watermark occupancy, only requester 0 (priority requester) may enqueue.
- Runs a four-phase drain-then-flush sequence, so the FIFO's pointer flush is only issued once every valid bit has cleared.

---
 rtl/l1d_fifo_enq_sched.sv | 133 +++++++++++++
 tb/tb_l1d_fifo_enq_sched.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/l1d_fifo_enq_sched.sv
// Enqueue-side scheduler for the L1D data/valid FIFO: round-robin arbitration of
// REQ_NUM requesters onto one enqueue port, high-watermark throttling, drain-then-flush.
module l1d_fifo_enq_sched #(
  parameter int REQ_NUM       = 4,
  parameter int PAYLOAD_WIDTH = 3,
  parameter int DEPTH         = 16,
  parameter int HWM           = 12
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [REQ_NUM-1:0]                      req_vld_i,
  input  logic [REQ_NUM-1:0][PAYLOAD_WIDTH-1:0]   req_payload_i,
  output logic [REQ_NUM-1:0]                      req_rdy_o,
  output logic                                    fifo_enq_vld_o,
  output logic [PAYLOAD_WIDTH-1:0]                fifo_enq_payload_o,
  input  logic                                    fifo_enq_rdy_i,
  input  logic [DEPTH-1:0]                        fifo_payload_vld_i,
  output logic                                    fifo_flush_o,
  input  logic                                    flush_req_i,
  output logic                                    flush_ack_o,
  output logic [$clog2(DEPTH+1)-1:0]              occupancy_o,
  output logic                                    busy_o
);

  // state | meaning
  // IDLE  | arbitrating; flush_req_i starts a flush sequence
  // DRAIN | grants blocked, waiting for every FIFO valid bit to clear
  // FLUSH | one-cycle pointer flush pulse to the FIFO
  // ACK   | flush_ack_o held until flush_req_i drops

  localparam int OCC_W = $clog2(DEPTH+1);
  localparam int PTR_W = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, DRAIN = 2'd1, FLUSH = 2'd2, ACK = 2'd3} state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [OCC_W-1:0]   occupancy_q, occupancy_d;
  logic [REQ_NUM-1:0] eligible;
  logic [PTR_W:0]     scan_idx;
  logic [PTR_W-1:0]   grant_idx;
  logic               any_elig;
  logic               grant_en;
  logic               fire;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      occupancy_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      occupancy_q <= occupancy_d;
    end
  end

  always_comb begin
    occupancy_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occupancy_d = occupancy_d + OCC_W'(fifo_payload_vld_i[i]);
    end
  end

  // Throttle uses the registered count, so it trails the FIFO by a cycle.
  always_comb begin
    eligible = req_vld_i;
    if (occupancy_q >= OCC_W'(HWM)) begin
      eligible[REQ_NUM-1:1] = '0;
    end
  end

  always_comb begin
    grant_idx = '0;
    any_elig  = 1'b0;
    scan_idx  = '0;
    for (int k = 0; k < REQ_NUM; k++) begin
      scan_idx = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
      if (scan_idx >= (PTR_W+1)'(REQ_NUM)) begin
        scan_idx = scan_idx - (PTR_W+1)'(REQ_NUM);
      end
      if (!any_elig && eligible[scan_idx[PTR_W-1:0]]) begin
        any_elig  = 1'b1;
        grant_idx = scan_idx[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    grant_en           = !rst && (state_q == IDLE) && !flush_req_i;
    fifo_enq_vld_o     = grant_en && any_elig;
    fifo_enq_payload_o = '0;
    req_rdy_o          = '0;
    if (fifo_enq_vld_o) begin
      fifo_enq_payload_o     = req_payload_i[grant_idx];
      req_rdy_o[grant_idx]   = fifo_enq_rdy_i;
    end
    fire     = fifo_enq_vld_o && fifo_enq_rdy_i;
    rr_ptr_d = rr_ptr_q;
    if (fire) begin
      rr_ptr_d = (grant_idx == PTR_W'(REQ_NUM-1)) ? '0 : grant_idx + PTR_W'(1);
    end
  end

  always_comb begin
    state_d      = state_q;
    fifo_flush_o = 1'b0;
    flush_ack_o  = 1'b0;
    busy_o       = 1'b0;
    case (state_q)
      IDLE:  if (flush_req_i) state_d = DRAIN;
      DRAIN: if (fifo_payload_vld_i == '0) state_d = FLUSH;
      FLUSH: begin
        fifo_flush_o = 1'b1;
        state_d      = ACK;
      end
      ACK: begin
        flush_ack_o = 1'b1;
        if (!flush_req_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (state_q != IDLE) busy_o = 1'b1;
    if (rst) begin
      fifo_flush_o = 1'b0;
      flush_ack_o  = 1'b0;
      busy_o       = 1'b0;
    end
  end

  assign occupancy_o = occupancy_q;

endmodule

// File: tb/tb_l1d_fifo_enq_sched.sv
// Directed bench for l1d_fifo_enq_sched: arbitration order, watermark throttle,
// full-FIFO hold, flush sequencing and reset behaviour.
module tb_l1d_fifo_enq_sched;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       req_vld_i;
  logic [3:0][2:0]  req_payload_i;
  logic [3:0]       req_rdy_o;
  logic             fifo_enq_vld_o;
  logic [2:0]       fifo_enq_payload_o;
  logic             fifo_enq_rdy_i;
  logic [15:0]      fifo_payload_vld_i;
  logic             fifo_flush_o;
  logic             flush_req_i;
  logic             flush_ack_o;
  logic [4:0]       occupancy_o;
  logic             busy_o;

  int n_chk = 0;
  int n_err = 0;
  int cnt;

  l1d_fifo_enq_sched #(.REQ_NUM(4), .PAYLOAD_WIDTH(3), .DEPTH(16), .HWM(12)) dut (
    .clk                (clk),
    .rst                (rst),
    .req_vld_i          (req_vld_i),
    .req_payload_i      (req_payload_i),
    .req_rdy_o          (req_rdy_o),
    .fifo_enq_vld_o     (fifo_enq_vld_o),
    .fifo_enq_payload_o (fifo_enq_payload_o),
    .fifo_enq_rdy_i     (fifo_enq_rdy_i),
    .fifo_payload_vld_i (fifo_payload_vld_i),
    .fifo_flush_o       (fifo_flush_o),
    .flush_req_i        (flush_req_i),
    .flush_ack_o        (flush_ack_o),
    .occupancy_o        (occupancy_o),
    .busy_o             (busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_vld_i = '0;
    flush_req_i = 1'b0;
    fifo_payload_vld_i = '0;
    fifo_enq_rdy_i = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [15:0] vec_of(input int n);
    logic [16:0] t;
    t = (17'd1 << n) - 17'd1;
    return t[15:0];
  endfunction

  initial begin
    req_payload_i[0] = 3'd1;
    req_payload_i[1] = 3'd2;
    req_payload_i[2] = 3'd3;
    req_payload_i[3] = 3'd4;

    // reset state, with requests already pending
    rst = 1'b1;
    req_vld_i = 4'b1111;
    fifo_enq_rdy_i = 1'b1;
    fifo_payload_vld_i = '0;
    flush_req_i = 1'b0;
    #2;
    chk("rst_req_rdy", 32'(req_rdy_o), 32'(0));
    chk("rst_enq_vld", 32'(fifo_enq_vld_o), 32'(0));
    chk("rst_busy", 32'(busy_o), 32'(0));
    chk("rst_flush", 32'(fifo_flush_o), 32'(0));
    chk("rst_ack", 32'(flush_ack_o), 32'(0));
    tick();
    tick();
    rst = 1'b0;

    // round robin with FIFO model, watermark throttle, then full
    cnt = 0;
    for (int c = 0; c <= 16; c++) begin
      fifo_payload_vld_i = vec_of(cnt);
      fifo_enq_rdy_i = (cnt < 16);
      #1;
      chk($sformatf("rr_rdy c%0d", c), 32'(req_rdy_o),
          (c <= 12) ? (32'(1) << (c % 4)) : ((c <= 15) ? 32'(1) : 32'(0)));
      chk($sformatf("rr_enq_vld c%0d", c), 32'(fifo_enq_vld_o), 32'(1));
      chk($sformatf("rr_payload c%0d", c), 32'(fifo_enq_payload_o),
          (c <= 12) ? 32'(c % 4 + 1) : 32'(1));
      chk($sformatf("rr_occ c%0d", c), 32'(occupancy_o), (c == 0) ? 32'(0) : 32'(c - 1));
      if (|(req_rdy_o & req_vld_i)) cnt++;
      tick();
    end

    // full FIFO holds rr_ptr
    do_reset();
    req_vld_i = 4'b0010;
    #1;
    chk("full_pre_rdy", 32'(req_rdy_o), 32'(4'b0010));
    tick();
    req_vld_i = 4'b0110;
    fifo_enq_rdy_i = 1'b0;
    fifo_payload_vld_i = 16'h0007;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk($sformatf("full_enq_vld c%0d", c), 32'(fifo_enq_vld_o), 32'(1));
      chk($sformatf("full_rdy c%0d", c), 32'(req_rdy_o), 32'(0));
      chk($sformatf("full_payload c%0d", c), 32'(fifo_enq_payload_o), 32'(3));
      tick();
    end
    fifo_enq_rdy_i = 1'b1;
    #1;
    chk("full_resume_first", 32'(req_rdy_o), 32'(4'b0100));
    tick();
    #1;
    chk("full_resume_second", 32'(req_rdy_o), 32'(4'b0010));
    tick();

    // drain then flush with 5 entries dequeued one per cycle
    do_reset();
    req_vld_i = 4'b0001;
    for (int c = 0; c <= 11; c++) begin
      fifo_payload_vld_i = (c < 5) ? vec_of(5 - c) : 16'h0000;
      flush_req_i = (c <= 9);
      #1;
      chk($sformatf("drain_rdy c%0d", c), 32'(req_rdy_o), (c == 11) ? 32'(1) : 32'(0));
      chk($sformatf("drain_flush c%0d", c), 32'(fifo_flush_o), 32'(c == 6));
      chk($sformatf("drain_ack c%0d", c), 32'(flush_ack_o), 32'(c >= 7 && c <= 10));
      chk($sformatf("drain_busy c%0d", c), 32'(busy_o), 32'(c >= 1 && c <= 10));
      if (c == 0) chk("drain_payload_nogrant", 32'(fifo_enq_payload_o), 32'(0));
      tick();
    end

    // empty flush, request held past ack
    req_vld_i = 4'b0000;
    fifo_payload_vld_i = '0;
    for (int c = 0; c <= 6; c++) begin
      flush_req_i = (c <= 4);
      #1;
      chk($sformatf("empty_flush c%0d", c), 32'(fifo_flush_o), 32'(c == 2));
      chk($sformatf("empty_ack c%0d", c), 32'(flush_ack_o), 32'(c >= 3 && c <= 5));
      chk($sformatf("empty_busy c%0d", c), 32'(busy_o), 32'(c >= 1 && c <= 5));
      tick();
    end

    // empty flush, request dropped before ack
    for (int c = 0; c <= 4; c++) begin
      flush_req_i = (c == 0);
      #1;
      chk($sformatf("early_flush c%0d", c), 32'(fifo_flush_o), 32'(c == 2));
      chk($sformatf("early_ack c%0d", c), 32'(flush_ack_o), 32'(c == 3));
      chk($sformatf("early_busy c%0d", c), 32'(busy_o), 32'(c >= 1 && c <= 3));
      tick();
    end

    // reset while draining
    do_reset();
    req_vld_i = 4'b0010;
    #1;
    chk("rstd_pre_rdy", 32'(req_rdy_o), 32'(4'b0010));
    tick();
    req_vld_i = 4'b0000;
    fifo_payload_vld_i = 16'h0003;
    flush_req_i = 1'b1;
    #1;
    chk("rstd_idle_busy", 32'(busy_o), 32'(0));
    tick();
    #1;
    chk("rstd_drain_busy", 32'(busy_o), 32'(1));
    chk("rstd_drain_flush", 32'(fifo_flush_o), 32'(0));
    tick();
    rst = 1'b1;
    req_vld_i = 4'b1111;
    #1;
    chk("rstd_inrst_busy", 32'(busy_o), 32'(0));
    chk("rstd_inrst_rdy", 32'(req_rdy_o), 32'(0));
    tick();
    rst = 1'b0;
    flush_req_i = 1'b0;
    fifo_payload_vld_i = '0;
    #1;
    chk("rstd_post_busy", 32'(busy_o), 32'(0));
    chk("rstd_post_flush", 32'(fifo_flush_o), 32'(0));
    chk("rstd_post_occ", 32'(occupancy_o), 32'(0));
    chk("rstd_post_rdy", 32'(req_rdy_o), 32'(4'b0001));
    tick();

    // flush and request rise together; single requester streams afterwards
    req_vld_i = 4'b1000;
    for (int c = 0; c <= 6; c++) begin
      flush_req_i = (c <= 3);
      #1;
      chk($sformatf("simul_rdy c%0d", c), 32'(req_rdy_o), (c >= 5) ? 32'(4'b1000) : 32'(0));
      chk($sformatf("simul_enq_vld c%0d", c), 32'(fifo_enq_vld_o), 32'(c >= 5));
      chk($sformatf("simul_ack c%0d", c), 32'(flush_ack_o), 32'(c == 3 || c == 4));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
